// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and frame-length helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_EVEN = 1;
   localparam int unsigned PARITY_ODD  = 2;

   // Clocks occupied by one complete frame on the line.
   function automatic int unsigned frame_clocks(input int unsigned data_bits,
                                                input int unsigned parity_mode,
                                                input int unsigned stop_bits,
                                                input int unsigned division);
      return (1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits) * division;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead read data; shared by the UART transmitter and receiver.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic             w_wr;
   logic             w_rd;

   // Extra pointer MSB tells a full FIFO apart from an empty one.
   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign o_level = r_wptr - r_rptr;
   assign o_rdata = r_mem[r_rptr[AW-1:0]];

   assign w_wr = i_push && !o_full;
   assign w_rd = i_pop && !o_empty;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + 1'b1;
         if (w_rd) r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO: configurable data width, parity and stop bits.
// Frames go out LSB-first on a registered line, back-to-back while the FIFO holds data.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned SYS_CLOCK   = 1000000,
   parameter int unsigned BAUD_RATE   = 9600,
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned PARITY_MODE = 0,
   parameter int unsigned STOP_BITS   = 1,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          in_valid,
   input  logic [DATA_BITS-1:0]          in_data,
   output logic                          in_ready,
   output logic                          busy,
   output logic                          tx_output,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned DIVISION = SYS_CLOCK / BAUD_RATE;
   localparam int unsigned CNT_W    = $clog2(DIVISION);
   localparam int unsigned IDX_W    = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIVISION - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

   if (DIVISION < 2) begin : g_bad_division
      $error("uart_tx_fifo: SYS_CLOCK/BAUD_RATE must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_fifo: DATA_BITS must be 5..9");
   end
   if (PARITY_MODE > PARITY_ODD) begin : g_bad_parity
      $error("uart_tx_fifo: PARITY_MODE must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
   end

   tx_state_t              r_state;
   tx_state_t              w_state_d;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       w_cnt_d;
   logic [IDX_W-1:0]       r_idx;
   logic [IDX_W-1:0]       w_idx_d;
   logic [DATA_BITS-1:0]   r_shift;
   logic [DATA_BITS-1:0]   w_shift_d;
   logic                   r_parity;
   logic                   w_parity_d;
   logic                   r_tx;
   logic                   w_tx_d;
   logic                   r_busy;
   logic                   w_bit_end;
   logic                   w_pop;
   logic                   w_full;
   logic                   w_empty;
   logic [DATA_BITS-1:0]   w_head;

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (in_valid),
      .i_wdata (in_data),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (fifo_level)
   );

   assign w_bit_end = (r_cnt == CNT_LAST);

   always_comb begin
      w_state_d  = r_state;
      w_cnt_d    = w_bit_end ? '0 : r_cnt + 1'b1;
      w_idx_d    = r_idx;
      w_shift_d  = r_shift;
      w_parity_d = r_parity;
      w_pop      = 1'b0;
      w_tx_d     = 1'b1;

      unique case (r_state)
         IDLE: begin
            w_cnt_d = '0;
            if (!w_empty) begin
               w_pop     = 1'b1;
               w_state_d = START;
            end
         end
         START: begin
            if (w_bit_end) begin
               w_state_d = DATA;
               w_idx_d   = '0;
            end
         end
         DATA: begin
            if (w_bit_end) begin
               w_shift_d = r_shift >> 1;
               if (r_idx == DATA_LAST) begin
                  w_idx_d   = '0;
                  w_state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
               end else begin
                  w_idx_d = r_idx + 1'b1;
               end
            end
         end
         PARITY: begin
            if (w_bit_end) begin
               w_state_d = STOP;
               w_idx_d   = '0;
            end
         end
         STOP: begin
            if (w_bit_end) begin
               if (r_idx == STOP_LAST) begin
                  // Chain straight into the next frame when more data is waiting.
                  if (!w_empty) begin
                     w_pop     = 1'b1;
                     w_state_d = START;
                  end else begin
                     w_state_d = IDLE;
                  end
               end else begin
                  w_idx_d = r_idx + 1'b1;
               end
            end
         end
         default: w_state_d = IDLE;
      endcase

      if (w_pop) begin
         w_shift_d  = w_head;
         w_parity_d = (PARITY_MODE == PARITY_EVEN) ? ^w_head : ~^w_head;
         w_idx_d    = '0;
      end

      // Line level follows the state being entered so tx_output can be a flop.
      case (w_state_d)
         START:   w_tx_d = 1'b0;
         DATA:    w_tx_d = w_shift_d[0];
         PARITY:  w_tx_d = w_parity_d;
         default: w_tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_shift  <= '0;
         r_parity <= 1'b0;
         r_tx     <= 1'b1;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_d;
         r_cnt    <= w_cnt_d;
         r_idx    <= w_idx_d;
         r_shift  <= w_shift_d;
         r_parity <= w_parity_d;
         r_tx     <= w_tx_d;
         r_busy   <= (w_state_d != IDLE);
      end
   end

   assign in_ready  = !w_full;
   assign busy      = r_busy;
   assign tx_output = r_tx;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: four configurations, a frame monitor with a
// scoreboard on the 8N1 instance, and direct waveform checks on the others.
module tb_uart_tx_fifo;

   localparam int DIV0 = 104;
   localparam int DIV1 = 10;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       v0, v1, v2, v3;
   logic [7:0] d0, d1, d2;
   logic [4:0] d3;
   logic       rdy0, rdy1, rdy2, rdy3;
   logic       busy0, busy1, busy2, busy3;
   logic       tx0, tx1, tx2, tx3;
   logic [2:0] lvl0, lvl1, lvl2, lvl3;

   int          checks = 0;
   int          errors = 0;
   int          frames_done = 0;
   int unsigned cyc = 0;
   bit          mon_en = 1'b1;
   logic [7:0]  sb[$];
   int unsigned starts[$];
   logic        cap_tx [4][128];
   logic        cap_bz [4][128];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_fifo #(.SYS_CLOCK(1000000), .BAUD_RATE(9600)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .in_valid(v0), .in_data(d0), .in_ready(rdy0),
      .busy(busy0), .tx_output(tx0), .fifo_level(lvl0));
   uart_tx_fifo #(.SYS_CLOCK(1000000), .BAUD_RATE(100000), .PARITY_MODE(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .in_valid(v1), .in_data(d1), .in_ready(rdy1),
      .busy(busy1), .tx_output(tx1), .fifo_level(lvl1));
   uart_tx_fifo #(.SYS_CLOCK(1000000), .BAUD_RATE(100000), .PARITY_MODE(2)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .in_valid(v2), .in_data(d2), .in_ready(rdy2),
      .busy(busy2), .tx_output(tx2), .fifo_level(lvl2));
   uart_tx_fifo #(.SYS_CLOCK(1000000), .BAUD_RATE(100000), .DATA_BITS(5), .STOP_BITS(2))
   u_dut3 (
      .clk(clk), .reset_n(reset_n), .in_valid(v3), .in_data(d3), .in_ready(rdy3),
      .busy(busy3), .tx_output(tx3), .fifo_level(lvl3));

   function automatic logic txs(input int w);
      case (w)
         0: return tx0;
         1: return tx1;
         2: return tx2;
         default: return tx3;
      endcase
   endfunction

   function automatic logic bsy(input int w);
      case (w)
         0: return busy0;
         1: return busy1;
         2: return busy2;
         default: return busy3;
      endcase
   endfunction

   function automatic logic rdy(input int w);
      case (w)
         0: return rdy0;
         1: return rdy1;
         2: return rdy2;
         default: return rdy3;
      endcase
   endfunction

   function automatic int lvl(input int w);
      case (w)
         0: return int'(lvl0);
         1: return int'(lvl1);
         2: return int'(lvl2);
         default: return int'(lvl3);
      endcase
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Offer one word for one edge; acc reports whether the handshake completed.
   task automatic push(input int w, input logic [7:0] data, output bit acc);
      case (w)
         0: begin v0 = 1'b1; d0 = data; end
         1: begin v1 = 1'b1; d1 = data; end
         2: begin v2 = 1'b1; d2 = data; end
         default: begin v3 = 1'b1; d3 = data[4:0]; end
      endcase
      acc = rdy(w);
      step(1);
      v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
      if (w == 0 && acc) sb.push_back(data);
   endtask

   task automatic capture(input int n);
      for (int i = 0; i < n; i++) begin
         for (int w = 0; w < 4; w++) begin
            cap_tx[w][i] = txs(w);
            cap_bz[w][i] = bsy(w);
         end
         step(1);
      end
   endtask

   task automatic wait_idle0(input int max, output bit tmo);
      int n;
      n = 0;
      while ((sb.size() != 0 || busy0 !== 1'b0) && n < max) begin
         step(1);
         n++;
      end
      tmo = (n >= max);
   endtask

   // Frame monitor for instance 0 (8N1): pops the scoreboard at each start bit.
   initial begin : monitor
      logic [7:0] w;
      logic       e;
      int         good;
      int         bhi;
      bit         ab;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en && reset_n && tx0 === 1'b0) begin
            starts.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL mon_unexpected_frame: got start bit at cycle %0d, need idle line", cyc);
               w = '0;
            end else begin
               w = sb.pop_front();
            end
            ab  = 1'b0;
            bhi = 0;
            for (int k = 0; k < 10 && !ab; k++) begin
               if (k == 0) e = 1'b0;
               else if (k == 9) e = 1'b1;
               else e = w[k-1];
               good = 0;
               for (int c = 0; c < DIV0; c++) begin
                  if (!mon_en || !reset_n) begin
                     ab = 1'b1;
                     break;
                  end
                  if (tx0 === e) good++;
                  if (busy0 === 1'b1) bhi++;
                  if (!(k == 9 && c == DIV0 - 1)) step(1);
               end
               if (!ab) begin
                  checks++;
                  if (good != DIV0) begin
                     errors++;
                     $display("FAIL mon_bit word=%h bit=%0d: got %0d cycles at %0d, need %0d",
                              w, k, good, e, DIV0);
                  end
               end
            end
            if (!ab) begin
               checks++;
               if (bhi != 10 * DIV0) begin
                  errors++;
                  $display("FAIL mon_busy word=%h: got %0d busy cycles, need %0d", w, bhi, 10 * DIV0);
               end
               frames_done++;
            end
         end
      end
   end

   task automatic test_reset();
      reset_n = 1'b0;
      step(3);
      for (int w = 0; w < 4; w++) begin
         checks += 4;
         if (txs(w) !== 1'b1) begin
            errors++; $display("FAIL reset_tx dut%0d: got %b, need 1", w, txs(w));
         end
         if (bsy(w) !== 1'b0) begin
            errors++; $display("FAIL reset_busy dut%0d: got %b, need 0", w, bsy(w));
         end
         if (lvl(w) != 0) begin
            errors++; $display("FAIL reset_level dut%0d: got %0d, need 0", w, lvl(w));
         end
         if (rdy(w) !== 1'b1) begin
            errors++; $display("FAIL reset_ready dut%0d: got %b, need 1", w, rdy(w));
         end
      end
      reset_n = 1'b1;
      step(2);
   endtask

   task automatic test_8n1();
      bit acc;
      int n;
      int f0;
      f0 = frames_done;
      push(0, 8'h55, acc);
      checks += 4;
      if (acc !== 1'b1) begin errors++; $display("FAIL 8n1_accept: got %b, need 1", acc); end
      if (lvl0 !== 3'd1) begin errors++; $display("FAIL 8n1_level_push: got %0d, need 1", lvl0); end
      if (tx0 !== 1'b1) begin errors++; $display("FAIL 8n1_tx_push: got %b, need 1", tx0); end
      if (busy0 !== 1'b0) begin errors++; $display("FAIL 8n1_busy_push: got %b, need 0", busy0); end
      step(1);
      checks += 3;
      if (tx0 !== 1'b0) begin errors++; $display("FAIL 8n1_tx_start: got %b, need 0", tx0); end
      if (busy0 !== 1'b1) begin errors++; $display("FAIL 8n1_busy_start: got %b, need 1", busy0); end
      if (lvl0 !== 3'd0) begin errors++; $display("FAIL 8n1_level_pop: got %0d, need 0", lvl0); end
      n = 0;
      while (busy0 === 1'b1 && n < 1200) begin
         n++;
         step(1);
      end
      checks += 3;
      if (n != 1040) begin errors++; $display("FAIL 8n1_busy_len: got %0d, need 1040", n); end
      if (tx0 !== 1'b1) begin errors++; $display("FAIL 8n1_tx_idle: got %b, need 1", tx0); end
      if (frames_done != f0 + 1) begin
         errors++; $display("FAIL 8n1_frames: got %0d, need %0d", frames_done - f0, 1);
      end
   endtask

   task automatic test_parity();
      logic [7:0] word;
      logic       e;
      int         good;
      int         bhi;
      word = 8'h07;
      v1 = 1'b1; d1 = word; v2 = 1'b1; d2 = word;
      step(1);
      v1 = 1'b0; v2 = 1'b0;
      step(1);
      capture(116);
      for (int w = 1; w <= 2; w++) begin
         for (int k = 0; k < 11; k++) begin
            if (k == 0) e = 1'b0;
            else if (k <= 8) e = word[k-1];
            else if (k == 9) e = (w == 1) ? 1'b1 : 1'b0;
            else e = 1'b1;
            good = 0;
            for (int c = 0; c < DIV1; c++) if (cap_tx[w][k*DIV1+c] === e) good++;
            checks++;
            if (good != DIV1) begin
               errors++;
               $display("FAIL parity_bit dut%0d bit=%0d: got %0d cycles at %0d, need %0d",
                        w, k, good, e, DIV1);
            end
         end
         bhi = 0;
         for (int i = 0; i < 116; i++) if (cap_bz[w][i] === 1'b1) bhi++;
         checks += 2;
         if (bhi != 11 * DIV1) begin
            errors++; $display("FAIL parity_frame_len dut%0d: got %0d, need %0d", w, bhi, 11 * DIV1);
         end
         if (cap_tx[w][110] !== 1'b1) begin
            errors++; $display("FAIL parity_idle dut%0d: got %b, need 1", w, cap_tx[w][110]);
         end
      end
   endtask

   task automatic test_5n2();
      logic [4:0] words [2];
      logic       e;
      int         good;
      int         bhi;
      bit         acc;
      words[0] = 5'h1F;
      words[1] = 5'h0A;
      for (int j = 0; j < 2; j++) begin
         push(3, {3'b111, words[j]}, acc);
         step(1);
         capture(90);
         for (int k = 0; k < 8; k++) begin
            if (k == 0) e = 1'b0;
            else if (k <= 5) e = words[j][k-1];
            else e = 1'b1;
            good = 0;
            for (int c = 0; c < DIV1; c++) if (cap_tx[3][k*DIV1+c] === e) good++;
            checks++;
            if (good != DIV1) begin
               errors++;
               $display("FAIL 5n2_bit word=%h bit=%0d: got %0d cycles at %0d, need %0d",
                        words[j], k, good, e, DIV1);
            end
         end
         bhi = 0;
         for (int i = 0; i < 90; i++) if (cap_bz[3][i] === 1'b1) bhi++;
         checks += 2;
         if (bhi != 8 * DIV1) begin
            errors++; $display("FAIL 5n2_frame_len: got %0d, need %0d", bhi, 8 * DIV1);
         end
         if (cap_tx[3][80] !== 1'b1) begin
            errors++; $display("FAIL 5n2_idle: got %b, need 1", cap_tx[3][80]);
         end
      end
   endtask

   task automatic test_fifo_full();
      int exp_lvl [6] = '{1, 1, 2, 3, 4, 4};
      bit acc;
      bit tmo;
      int s0;
      int gap;
      s0 = starts.size();
      for (int i = 0; i < 6; i++) begin
         push(0, 8'hA0 + 8'(i), acc);
         checks += 2;
         if (acc !== (i < 5)) begin
            errors++; $display("FAIL full_ready push=%0d: got %b, need %b", i, acc, (i < 5));
         end
         if (int'(lvl0) != exp_lvl[i]) begin
            errors++; $display("FAIL full_level push=%0d: got %0d, need %0d", i, lvl0, exp_lvl[i]);
         end
      end
      wait_idle0(7000, tmo);
      checks += 2;
      if (tmo) begin errors++; $display("FAIL full_drain: got timeout, need idle"); end
      if (starts.size() - s0 != 5) begin
         errors++; $display("FAIL full_frames: got %0d, need 5", starts.size() - s0);
      end
      for (int i = 0; i < 4; i++) begin
         gap = (starts.size() >= s0 + i + 2) ? int'(starts[s0+i+1] - starts[s0+i]) : -1;
         checks++;
         if (gap != 10 * DIV0) begin
            errors++; $display("FAIL full_b2b frame=%0d: got gap %0d, need %0d", i, gap, 10 * DIV0);
         end
      end
   endtask

   task automatic test_push_at_stop_end();
      bit acc;
      bit tmo;
      int s0;
      int gap;
      s0 = starts.size();
      push(0, 8'h3C, acc);
      step(1);
      step(10 * DIV0 - 1);
      push(0, 8'hC3, acc);
      checks += 4;
      if (acc !== 1'b1) begin errors++; $display("FAIL stopend_accept: got %b, need 1", acc); end
      if (busy0 !== 1'b0) begin errors++; $display("FAIL stopend_busy: got %b, need 0", busy0); end
      if (tx0 !== 1'b1) begin errors++; $display("FAIL stopend_tx: got %b, need 1", tx0); end
      if (lvl0 !== 3'd1) begin errors++; $display("FAIL stopend_level: got %0d, need 1", lvl0); end
      step(1);
      checks += 2;
      if (tx0 !== 1'b0) begin errors++; $display("FAIL stopend_start: got %b, need 0", tx0); end
      if (busy0 !== 1'b1) begin errors++; $display("FAIL stopend_busy2: got %b, need 1", busy0); end
      wait_idle0(2000, tmo);
      gap = (starts.size() >= s0 + 2) ? int'(starts[s0+1] - starts[s0]) : -1;
      checks += 2;
      if (tmo) begin errors++; $display("FAIL stopend_drain: got timeout, need idle"); end
      if (gap != 10 * DIV0 + 1) begin
         errors++; $display("FAIL stopend_gap: got %0d, need %0d", gap, 10 * DIV0 + 1);
      end
   endtask

   task automatic test_reset_mid_frame();
      bit acc;
      int bad;
      push(0, 8'h11, acc);
      push(0, 8'h22, acc);
      push(0, 8'h33, acc);
      step(2 * DIV0 + 50);
      checks += 2;
      if (lvl0 !== 3'd2) begin errors++; $display("FAIL rstmid_level_pre: got %0d, need 2", lvl0); end
      if (busy0 !== 1'b1) begin errors++; $display("FAIL rstmid_busy_pre: got %b, need 1", busy0); end
      mon_en = 1'b0;
      reset_n = 1'b0;
      #1;
      checks += 4;
      if (tx0 !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b, need 1", tx0); end
      if (busy0 !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, need 0", busy0); end
      if (lvl0 !== 3'd0) begin errors++; $display("FAIL rstmid_level: got %0d, need 0", lvl0); end
      if (rdy0 !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b, need 1", rdy0); end
      sb.delete();
      step(3);
      reset_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 2000; i++) begin
         if (tx0 !== 1'b1 || busy0 !== 1'b0 || lvl0 !== 3'd0) bad++;
         step(1);
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rstmid_resume: got %0d active cycles, need 0", bad); end
      mon_en = 1'b1;
   endtask

   task automatic test_random();
      bit acc;
      bit tmo;
      int nacc;
      int f0;
      f0 = frames_done;
      nacc = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            push(0, 8'($urandom), acc);
            if (acc) nacc++;
         end else begin
            step(1);
         end
      end
      wait_idle0(8000, tmo);
      checks += 3;
      if (tmo) begin errors++; $display("FAIL random_drain: got timeout, need idle"); end
      if (frames_done - f0 != nacc) begin
         errors++; $display("FAIL random_frames: got %0d, need %0d", frames_done - f0, nacc);
      end
      if (sb.size() != 0) begin
         errors++; $display("FAIL random_scoreboard: got %0d left, need 0", sb.size());
      end
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got time limit, need completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
      d0 = '0; d1 = '0; d2 = '0; d3 = '0;
      test_reset();
      test_8n1();
      test_parity();
      test_5n2();
      test_fifo_full();
      test_push_at_stop_end();
      test_reset_mid_frame();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
